// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: engine-side and pin-side signal bundle of the SDRAM command arbiter
//   slave  modport: arbiter view (engine requests/commands in, grants and pins out)
//   master modport: engine/pin view (requests/commands out, grants and pins in)
//   init_*  : init engine end/cmd/addr
//   ref_*   : refresh engine req/end/cmd/addr, ref_en grant
//   wr_*    : write engine req/end/cmd/addr/bank/data, wr_en grant
//   rd_*    : read engine req/end/cmd/addr/bank, rd_en grant
//   refresh_req, sdram_cmd/addr/ba/dq/dq_oe, tmo_err : arbiter outputs
interface sdram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic              ref_req;
    logic              ref_end;
    logic [3:0]        ref_cmd;
    logic [ADDR_W-1:0] ref_addr;
    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_bank;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_bank;
    logic              ref_en;
    logic              wr_en;
    logic              rd_en;
    logic              refresh_req;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [1:0]        sdram_ba;
    logic [DATA_W-1:0] sdram_dq;
    logic              sdram_dq_oe;
    logic              tmo_err;
    modport slave (
        input  init_end, init_cmd, init_addr,
        input  ref_req, ref_end, ref_cmd, ref_addr,
        input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_en, wr_en, rd_en, refresh_req,
        output sdram_cmd, sdram_addr, sdram_ba, sdram_dq, sdram_dq_oe, tmo_err
    );
    modport master (
        output init_end, init_cmd, init_addr,
        output ref_req, ref_end, ref_cmd, ref_addr,
        output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_en, wr_en, rd_en, refresh_req,
        input  sdram_cmd, sdram_addr, sdram_ba, sdram_dq, sdram_dq_oe, tmo_err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM command bus to refresh > write > read after init
//   sys_clk : clock, rising edge
//   sys_rst : synchronous active-high reset
//   bus     : sdram_arbiter_if.slave (engine requests/commands, grants, registered pins)
//   ARB_RR_EN (macro): defined -> round-robin write/read tie-break; undefined -> write wins
//   GRANT_TMO: cycles allowed in one grant before forced release (0 disables the watchdog)
module sdram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int GRANT_TMO = 1023
) (
    input logic           sys_clk,
    input logic           sys_rst,
    sdram_arbiter_if.slave bus
);
    localparam logic [4:0] S_INIT  = 5'b00001;
    localparam logic [4:0] S_ARBIT = 5'b00010;
    localparam logic [4:0] S_AREF  = 5'b00100;
    localparam logic [4:0] S_WRITE = 5'b01000;
    localparam logic [4:0] S_READ  = 5'b10000;
    localparam logic [3:0] NOP     = 4'b0111;
    localparam int CW = (GRANT_TMO > 0) ? $clog2(GRANT_TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((GRANT_TMO > 0) ? GRANT_TMO - 1 : 0);
    logic [4:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        ba_q, ba_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic              dq_oe_q, ref_en_q, wr_en_q, rd_en_q, tmo_err_q;
    logic              granted, end_hit, tmo, arb, pick_ref, pick_wr, pick_rd, wr_wins;
`ifdef ARB_RR_EN
    logic              last_wr_q;
    // Break a write/read tie in favour of whichever was not served last
    assign wr_wins = !bus.rd_req || !last_wr_q;
`else
    assign wr_wins = 1'b1;
`endif
    always_comb begin
        granted  = |(state_q & (S_AREF | S_WRITE | S_READ));
        end_hit  = (state_q == S_AREF && bus.ref_end) || (state_q == S_WRITE && bus.wr_end) ||
                   (state_q == S_READ && bus.rd_end);
        tmo      = (GRANT_TMO != 0) && granted && cnt_q == TMO_LAST;
        arb      = state_q == S_ARBIT;
        pick_ref = arb && bus.ref_req;
        pick_wr  = arb && !bus.ref_req && bus.wr_req && wr_wins;
        pick_rd  = arb && !bus.ref_req && bus.rd_req && !pick_wr;
        state_d  = (state_q == S_INIT) ? (bus.init_end ? S_ARBIT : S_INIT) :
                   pick_ref ? S_AREF : pick_wr ? S_WRITE : pick_rd ? S_READ :
                   (end_hit || tmo) ? S_ARBIT : state_q;
        cnt_d    = (state_d != state_q || !granted) ? '0 : cnt_q + 1'b1;
        cmd_d    = tmo ? NOP : (state_q == S_INIT) ? bus.init_cmd : (state_q == S_AREF) ? bus.ref_cmd :
                   (state_q == S_WRITE) ? bus.wr_cmd : (state_q == S_READ) ? bus.rd_cmd : NOP;
        addr_d   = tmo ? '0 : (state_q == S_INIT) ? bus.init_addr : (state_q == S_AREF) ? bus.ref_addr :
                   (state_q == S_WRITE) ? bus.wr_addr : (state_q == S_READ) ? bus.rd_addr : '0;
        ba_d     = tmo ? 2'd0 : (state_q == S_WRITE) ? bus.wr_bank : (state_q == S_READ) ? bus.rd_bank : 2'd0;
        dq_d     = (state_q == S_WRITE && !tmo) ? bus.wr_data : '0;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            cmd_q     <= NOP;
            addr_q    <= '0;
            ba_q      <= 2'd0;
            dq_q      <= '0;
            dq_oe_q   <= 1'b0;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ba_q      <= ba_d;
            dq_q      <= dq_d;
            // Follows the next state so the bus is released in the same cycle the grant ends
            dq_oe_q   <= state_d == S_WRITE;
            ref_en_q  <= pick_ref;
            wr_en_q   <= pick_wr;
            rd_en_q   <= pick_rd;
            tmo_err_q <= tmo_err_q || tmo;
        end
    end
`ifdef ARB_RR_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) last_wr_q <= 1'b0;
        else if (pick_wr || pick_rd) last_wr_q <= pick_wr;
    end
`endif
    assign bus.refresh_req = bus.ref_req && (state_q == S_WRITE || state_q == S_READ);
    assign bus.ref_en      = ref_en_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.sdram_cmd   = cmd_q;
    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_ba    = ba_q;
    assign bus.sdram_dq    = dq_q;
    assign bus.sdram_dq_oe = dq_oe_q;
    assign bus.tmo_err     = tmo_err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed-vector bench for sdram_arbiter (main instance plus an 8-cycle watchdog instance)
module tb_sdram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    sdram_arbiter_if #(.ADDR_W(12), .DATA_W(16)) b0 ();
    sdram_arbiter_if #(.ADDR_W(12), .DATA_W(16)) b1 ();
    sdram_arbiter #(.ADDR_W(12), .DATA_W(16), .GRANT_TMO(1023)) dut (.sys_clk(clk), .sys_rst(rst), .bus(b0));
    sdram_arbiter #(.ADDR_W(12), .DATA_W(16), .GRANT_TMO(8)) dut_wd (.sys_clk(clk), .sys_rst(rst1), .bus(b1));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_bus0();
        {b0.init_end, b0.ref_req, b0.ref_end, b0.wr_req, b0.wr_end, b0.rd_req, b0.rd_end} = '0;
        b0.init_cmd = 4'b0111; b0.init_addr = '0; b0.ref_cmd = 4'b0111; b0.ref_addr = '0;
        b0.wr_cmd = 4'b0111; b0.wr_addr = '0; b0.wr_bank = '0; b0.wr_data = '0;
        b0.rd_cmd = 4'b0111; b0.rd_addr = '0; b0.rd_bank = '0;
    endtask
    task automatic idle_bus1();
        {b1.init_end, b1.ref_req, b1.ref_end, b1.wr_req, b1.wr_end, b1.rd_req, b1.rd_end} = '0;
        b1.init_cmd = 4'b0111; b1.init_addr = '0; b1.ref_cmd = 4'b0111; b1.ref_addr = '0;
        b1.wr_cmd = 4'b0111; b1.wr_addr = '0; b1.wr_bank = '0; b1.wr_data = '0;
        b1.rd_cmd = 4'b0111; b1.rd_addr = '0; b1.rd_bank = '0;
    endtask
    initial begin
        idle_bus0();
        idle_bus1();
        // T1: reset and init
        repeat (4) step();
        chk("rst_cmd", 32'(b0.sdram_cmd), 32'h7);
        chk("rst_addr", 32'(b0.sdram_addr), 32'h0);
        chk("rst_oe", 32'(b0.sdram_dq_oe), 32'h0);
        chk("rst_en", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        chk("rst_tmo", 32'(b0.tmo_err), 32'h0);
        rst = 1'b0;
        b0.init_cmd = 4'b0001; b0.init_addr = 12'h123;
        b0.ref_req = 1'b1; b0.wr_req = 1'b1; b0.rd_req = 1'b1;
        step();
        chk("init_cmd", 32'(b0.sdram_cmd), 32'h1);
        chk("init_addr", 32'(b0.sdram_addr), 32'h123);
        b0.init_cmd = 4'b0000;
        repeat (3) step();
        chk("init_cmd2", 32'(b0.sdram_cmd), 32'h0);
        chk("init_no_en", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        b0.init_end = 1'b1;
        step();
        chk("arbit_no_en", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        // T2: refresh beats write and read
        b0.ref_cmd = 4'b0001; b0.ref_addr = 12'h400;
        step();
        chk("prio_ref", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h4);
        chk("arbit_nop", 32'(b0.sdram_cmd), 32'h7);
        b0.ref_req = 1'b0;
        step();
        chk("aref_cmd", 32'(b0.sdram_cmd), 32'h1);
        chk("aref_addr", 32'(b0.sdram_addr), 32'h400);
        chk("aref_ba", 32'(b0.sdram_ba), 32'h0);
        b0.ref_end = 1'b1;
        step();
        b0.ref_end = 1'b0;
        chk("gap_after_ref", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        b0.wr_cmd = 4'b0100; b0.wr_addr = 12'h00C; b0.wr_data = 16'h0003; b0.wr_bank = 2'd2;
        step();
        chk("prio_wr", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h2);
        b0.wr_req = 1'b0;
        // T4: write muxing
        step();
        chk("wr_cmd", 32'(b0.sdram_cmd), 32'h4);
        chk("wr_addr", 32'(b0.sdram_addr), 32'h00C);
        chk("wr_dq", 32'(b0.sdram_dq), 32'h0003);
        chk("wr_ba", 32'(b0.sdram_ba), 32'h2);
        chk("wr_oe", 32'(b0.sdram_dq_oe), 32'h1);
        chk("no_refreq", 32'(b0.refresh_req), 32'h0);
        // T3: refresh request during write
        b0.ref_req = 1'b1;
        #1;
        chk("refreq_wr", 32'(b0.refresh_req), 32'h1);
        repeat (3) step();
        chk("refreq_hold", 32'(b0.refresh_req), 32'h1);
        chk("wr_no_regrant", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        b0.wr_end = 1'b1;
        step();
        b0.wr_end = 1'b0;
        chk("wrend_oe", 32'(b0.sdram_dq_oe), 32'h0);
        chk("wrend_refreq", 32'(b0.refresh_req), 32'h0);
        chk("wrend_no_en", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        step();
        chk("ref_after_wr", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h4);
        b0.ref_req = 1'b0;
        b0.ref_end = 1'b1;
        step();
        b0.ref_end = 1'b0;
        step();
        chk("rd_grant", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h1);
        b0.rd_cmd = 4'b0101; b0.rd_addr = 12'h0A5; b0.rd_bank = 2'd1;
        step();
        chk("rd_cmd", 32'(b0.sdram_cmd), 32'h5);
        chk("rd_addr", 32'(b0.sdram_addr), 32'h0A5);
        chk("rd_ba", 32'(b0.sdram_ba), 32'h1);
        chk("rd_oe", 32'(b0.sdram_dq_oe), 32'h0);
        // Write/read tie: after a read, write is served in both modes
        b0.wr_req = 1'b1;
        b0.rd_end = 1'b1;
        step();
        b0.rd_end = 1'b0;
        step();
        chk("tie1", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h2);
        b0.wr_end = 1'b1;
        step();
        b0.wr_end = 1'b0;
        step();
`ifdef ARB_RR_EN
        chk("tie2_rr", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h1);
`else
        chk("tie2_fixed", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h2);
`endif
        // Stray end from a non-granted engine keeps the grant
        b0.ref_end = 1'b1;
        step();
        b0.ref_end = 1'b0;
        step();
`ifdef ARB_RR_EN
        chk("stray_cmd", 32'(b0.sdram_cmd), 32'h5);
`else
        chk("stray_cmd", 32'(b0.sdram_cmd), 32'h4);
`endif
        chk("stray_no_en", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        // T6: reset mid-grant
        rst = 1'b1;
        step();
        chk("rst_mid_cmd", 32'(b0.sdram_cmd), 32'h7);
        chk("rst_mid_oe", 32'(b0.sdram_dq_oe), 32'h0);
        chk("rst_mid_en", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        b0.init_end = 1'b0;
        rst = 1'b0;
        step();
        chk("rst_mid_init", 32'({b0.ref_en, b0.wr_en, b0.rd_en}), 32'h0);
        chk("rst_mid_initcmd", 32'(b0.sdram_cmd), 32'h0);
        // T5: watchdog on an 8-cycle instance
        rst1 = 1'b0;
        b1.init_end = 1'b1; b1.rd_req = 1'b1; b1.rd_cmd = 4'b0101;
        step();
        step();
        chk("wd_grant", 32'(b1.rd_en), 32'h1);
        b1.rd_req = 1'b0;
        repeat (7) step();
        chk("wd_before", 32'(b1.tmo_err), 32'h0);
        chk("wd_before_cmd", 32'(b1.sdram_cmd), 32'h5);
        step();
        chk("wd_tmo", 32'(b1.tmo_err), 32'h1);
        chk("wd_nop", 32'(b1.sdram_cmd), 32'h7);
        b1.rd_req = 1'b1;
        step();
        chk("wd_arbit", 32'(b1.rd_en), 32'h1);
        b1.rd_req = 1'b0;
        b1.rd_end = 1'b1;
        step();
        b1.rd_end = 1'b0;
        repeat (3) step();
        chk("wd_sticky", 32'(b1.tmo_err), 32'h1);
        rst1 = 1'b1;
        step();
        chk("wd_clr", 32'(b1.tmo_err), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
